// File: rtl/tcdm_bank_responder.sv
// Single-bank TCDM responder: round-robin grant across NPORTS requesters,
// one access per cycle, registered response exactly one cycle after grant.
module tcdm_bank_responder #(
   parameter int unsigned NPORTS = 4,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = 20
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NPORTS-1:0]               tcdm_req_i,
   input  logic [NPORTS-1:0][ADDR_W-1:0]   tcdm_addr_i,
   input  logic [NPORTS-1:0]               tcdm_wen_i,
   input  logic [NPORTS-1:0][3:0]          tcdm_be_i,
   input  logic [NPORTS-1:0][31:0]         tcdm_wdata_i,
   output logic [NPORTS-1:0]               tcdm_gnt_o,
   output logic [NPORTS-1:0]               tcdm_valid_o,
   output logic [NPORTS-1:0]               tcdm_fmo_o,
   output logic [NPORTS-1:0][31:0]         tcdm_rdata_o
);

   localparam int unsigned PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int unsigned IDX_W  = ADDR_W - 2;
   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]              mem [DEPTH];
   logic [PTR_W-1:0]         ptr_q;
   logic [PTR_W-1:0]         gnt_idx;
   logic                     gnt_any;
   int unsigned              cand;

   logic [ADDR_W-1:0]        sel_addr;
   logic [IDX_W-1:0]         sel_idx;
   logic [MEM_AW-1:0]        mem_idx;
   logic                     sel_wen;
   logic [3:0]               sel_be;
   logic [31:0]              sel_wdata;
   logic                     in_range;
   logic                     unused_addr_lsb;

   logic [NPORTS-1:0]        valid_d, valid_q;
   logic [NPORTS-1:0]        fmo_d, fmo_q;
   logic [NPORTS-1:0][31:0]  rdata_d, rdata_q;

   // Round-robin search starting at ptr; reset masks all grants
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
         cand = (32'(ptr_q) + i) % NPORTS;
         if (!gnt_any && tcdm_req_i[PTR_W'(cand)]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(cand);
         end
      end
      if (!rst_ni) gnt_any = 1'b0;
   end

   always_comb begin
      tcdm_gnt_o = '0;
      if (gnt_any) tcdm_gnt_o[gnt_idx] = 1'b1;
   end

   assign sel_addr        = tcdm_addr_i[gnt_idx];
   assign sel_idx         = sel_addr[ADDR_W-1:2];
   assign mem_idx         = sel_idx[MEM_AW-1:0];
   assign sel_wen         = tcdm_wen_i[gnt_idx];
   assign sel_be          = tcdm_be_i[gnt_idx];
   assign sel_wdata       = tcdm_wdata_i[gnt_idx];
   assign in_range        = (32'(sel_idx) < DEPTH);
   assign unused_addr_lsb = ^sel_addr[1:0];

   // Response for the granted port, presented on the following cycle
   always_comb begin
      valid_d = '0;
      fmo_d   = '0;
      rdata_d = '0;
      if (gnt_any) begin
         valid_d[gnt_idx] = 1'b1;
         fmo_d[gnt_idx]   = !in_range;
         if (in_range && sel_wen) rdata_d[gnt_idx] = mem[mem_idx];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q   <= '0;
         valid_q <= '0;
         fmo_q   <= '0;
         rdata_q <= '0;
      end else begin
         if (gnt_any) ptr_q <= PTR_W'((32'(gnt_idx) + 32'd1) % NPORTS);
         valid_q <= valid_d;
         fmo_q   <= fmo_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is intentionally not reset
   always_ff @(posedge clk_i) begin
      if (gnt_any && in_range && !sel_wen) begin
         for (int k = 0; k < 4; k++) begin
            if (sel_be[k]) mem[mem_idx][8*k +: 8] <= sel_wdata[8*k +: 8];
         end
      end
   end

   assign tcdm_valid_o = valid_q;
   assign tcdm_fmo_o   = fmo_q;
   assign tcdm_rdata_o = rdata_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder: reference arbiter/memory model
// pushes expected responses to a scoreboard, popped one cycle after grant.
module tb_tcdm_bank_responder;

   localparam int NP    = 4;
   localparam int DEPTH = 1024;
   localparam int AW    = 20;

   typedef struct packed {
      logic [NP-1:0]        v;
      logic [NP-1:0]        f;
      logic [NP-1:0][31:0]  d;
   } resp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NP-1:0]        req, wen, gnt, valid, fmo;
   logic [NP-1:0][AW-1:0] addr;
   logic [NP-1:0][3:0]   be;
   logic [NP-1:0][31:0]  wdata, rdata;

   int          errors = 0;
   int          checks = 0;
   int          mptr   = 0;
   logic [31:0] mdl [int];
   resp_t       sb [$];

   always #5 clk = ~clk;

   tcdm_bank_responder #(.NPORTS(NP), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .tcdm_req_i   (req),
      .tcdm_addr_i  (addr),
      .tcdm_wen_i   (wen),
      .tcdm_be_i    (be),
      .tcdm_wdata_i (wdata),
      .tcdm_gnt_o   (gnt),
      .tcdm_valid_o (valid),
      .tcdm_fmo_o   (fmo),
      .tcdm_rdata_o (rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      req[p]   = 1'b1;
      wen[p]   = w;
      addr[p]  = a;
      be[p]    = b;
      wdata[p] = d;
   endtask

   // Model arbitration and storage; check gnt and queue the expected response
   task automatic grant_phase(output int g);
      resp_t         e;
      logic [NP-1:0] exp_g;
      logic [31:0]   w;
      int            idx;
      #3;
      g = -1;
      for (int k = 0; k < NP; k++) begin
         int p;
         p = (mptr + k) % NP;
         if (g < 0 && req[p]) g = p;
      end
      exp_g = '0;
      if (g >= 0) exp_g[g] = 1'b1;
      chk("gnt", 32'(gnt), 32'(exp_g));
      e = '0;
      if (g >= 0) begin
         idx    = int'(addr[g][AW-1:2]);
         e.v[g] = 1'b1;
         e.f[g] = (idx >= DEPTH);
         if (idx < DEPTH) begin
            w = mdl.exists(idx) ? mdl[idx] : 32'h0;
            if (wen[g]) e.d[g] = w;
            else begin
               for (int k = 0; k < 4; k++)
                  if (be[g][k]) w[8*k +: 8] = wdata[g][8*k +: 8];
               mdl[idx] = w;
            end
         end
         mptr = (g + 1) % NP;
      end
      sb.push_back(e);
   endtask

   task automatic resp_phase();
      resp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk("valid", 32'(valid), 32'(e.v));
         chk("fmo", 32'(fmo), 32'(e.f));
         for (int p = 0; p < NP; p++) chk($sformatf("rdata%0d", p), rdata[p], e.d[p]);
      end
   endtask

   task automatic cycle(output int g);
      grant_phase(g);
      resp_phase();
      if (g >= 0) req[g] = 1'b0;
   endtask

   task automatic drain();
      int g;
      for (int n = 0; n < 4*NP && req != '0; n++) cycle(g);
      chk("drain_done", 32'(req), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      req = '0; wen = '0; addr = '0; be = '0; wdata = '0;

      // Reset state: no grant even with all ports requesting
      req = '1;
      #2;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_fmo", 32'(fmo), 32'd0);
      for (int p = 0; p < NP; p++) chk("rst_rdata", rdata[p], 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req   = '0;

      // Round-robin fairness from reset, all ports re-requesting every cycle
      for (int c = 0; c < 8; c++) begin
         for (int p = 0; p < NP; p++) drive(p, 1'b0, AW'(20'h100 + 4*p), 4'b0000, 32'h0);
         cycle(g);
         chk("rr_order", 32'(g), 32'(c % NP));
      end
      req = '0;
      cycle(g);

      // Single write then read
      drive(0, 1'b0, 20'h00010, 4'b1111, 32'hDEADBEEF);
      cycle(g);
      drive(0, 1'b1, 20'h00010, 4'b0000, 32'h0);
      cycle(g);
      chk("wr_rd_data", rdata[0], 32'hDEADBEEF);

      // Byte enables
      drive(0, 1'b0, 20'h00020, 4'b1111, 32'hFFFFFFFF);
      cycle(g);
      drive(0, 1'b0, 20'h00020, 4'b0101, 32'h00000000);
      cycle(g);
      drive(0, 1'b1, 20'h00020, 4'b1111, 32'h0);
      cycle(g);
      chk("be_data", rdata[0], 32'hFF00FF00);

      // Out-of-range write must not alias onto word 0
      drive(0, 1'b0, 20'h00000, 4'b1111, 32'hCAFEF00D);
      cycle(g);
      drive(2, 1'b0, 20'h01000, 4'b1111, 32'h12345678);
      cycle(g);
      chk("oob_fmo", 32'(fmo[2]), 32'd1);
      chk("oob_rdata", rdata[2], 32'd0);
      drive(2, 1'b1, 20'h00000, 4'b0000, 32'h0);
      cycle(g);
      chk("oob_word0", rdata[2], 32'hCAFEF00D);
      drive(3, 1'b1, 20'hFFFFC, 4'b1111, 32'h0);
      cycle(g);
      chk("oob_rd_fmo", 32'(fmo[3]), 32'd1);

      // Write-then-read on consecutive grants from different ports
      drive(1, 1'b0, 20'h00040, 4'b1111, 32'hA5A5A5A5);
      cycle(g);
      drive(3, 1'b1, 20'h00040, 4'b0000, 32'h0);
      cycle(g);
      chk("fwd_data", rdata[3], 32'hA5A5A5A5);

      // Contention with mixed operations, requests held until granted
      drive(0, 1'b0, 20'h00044, 4'b1111, 32'h11112222);
      drive(2, 1'b1, 20'h00010, 4'b0000, 32'h0);
      drive(3, 1'b0, 20'h00048, 4'b1111, 32'h33334444);
      drain();
      drive(1, 1'b1, 20'h00044, 4'b0000, 32'h0);
      drive(3, 1'b1, 20'h00048, 4'b0000, 32'h0);
      drive(0, 1'b0, 20'h00048, 4'b1100, 32'h55550000);
      drain();

      // Reset in the cycle after a granted read drops its response
      drive(0, 1'b1, 20'h00040, 4'b0000, 32'h0);
      grant_phase(g);
      chk("pre_rst_gnt", 32'(g), 32'd0);
      req = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      void'(sb.pop_front());
      #1;
      chk("mid_rst_valid", 32'(valid), 32'd0);
      chk("mid_rst_fmo", 32'(fmo), 32'd0);
      chk("mid_rst_rdata0", rdata[0], 32'd0);
      req = '1;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      req = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_valid", 32'(valid), 32'd0);
      rst_n = 1'b1;
      mptr  = 0;
      #1;
      chk("post_rst_valid", 32'(valid), 32'd0);
      drive(1, 1'b1, 20'h00010, 4'b0000, 32'h0);
      drive(0, 1'b1, 20'h00040, 4'b0000, 32'h0);
      cycle(g);
      chk("post_rst_first", 32'(g), 32'd0);
      chk("post_rst_rd0", rdata[0], 32'hA5A5A5A5);
      cycle(g);
      chk("post_rst_second", 32'(g), 32'd1);
      chk("post_rst_rd1", rdata[1], 32'hDEADBEEF);
      cycle(g);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tcdm_bank_responder.md
TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 SHALL have parameter NPORTS, default 4: number of TCDM requester ports, p = 0..NPORTS-1.
REQ-002 SHALL have parameter DEPTH, default 1024: storage words, 32 bit each, power of two.
REQ-003 SHALL have parameter ADDR_W, default 20: byte-address width.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port tcdm_req_i, input, NPORTS bits: per-port request.
REQ-007 SHALL have port tcdm_addr_i, input, NPORTS x ADDR_W bits: per-port byte address; the word index is addr[ADDR_W-1:2].
REQ-008 SHALL have port tcdm_wen_i, input, NPORTS bits: per-port, 1 = read, 0 = write.
REQ-009 SHALL have port tcdm_be_i, input, NPORTS x 4 bits: per-port byte enables.
REQ-010 SHALL have port tcdm_wdata_i, input, NPORTS x 32 bits: per-port write data.
REQ-011 SHALL have port tcdm_gnt_o, output, NPORTS bits: per-port grant.
REQ-012 SHALL have port tcdm_valid_o, output, NPORTS bits: per-port response valid.
REQ-013 SHALL have port tcdm_fmo_o, output, NPORTS bits: per-port error flag, qualified by valid.
REQ-014 SHALL have port tcdm_rdata_o, output, NPORTS x 32 bits: per-port read data.

Function
REQ-015 SHALL assert at most one tcdm_gnt_o bit per cycle, combinationally from tcdm_req_i in that same cycle.
REQ-016 SHALL grant only a port whose req is high; with no req high, tcdm_gnt_o = 0.
REQ-017 SHALL arbitrate round-robin:
- a priority pointer ptr, reset 0, selects the first requesting port searching ptr, ptr+1, ... modulo NPORTS;
- after a grant to port g, ptr becomes (g+1) mod NPORTS;
- ptr is unchanged in a cycle with no grant.
REQ-018 SHALL rely on requesters holding req, addr, wen, be and wdata stable until gnt; a req withdrawn before gnt is dropped without side effects.
REQ-019 SHALL write an in-range granted write in the grant cycle: only bytes with be[k]=1 are updated; be=0000 writes nothing but still responds.
REQ-020 SHALL sample an in-range granted read in the grant cycle; be is ignored on reads.
REQ-021 SHALL treat a word index >= DEPTH as out of range:
- the request is still granted;
- storage is not modified;
- the response carries fmo=1 and rdata=0.
REQ-022 SHALL respond exactly one cycle after each grant (reads and writes alike):
- valid_o[g]=1 for one cycle;
- fmo_o[g] as defined in REQ-021;
- rdata_o[g] = read data for reads, 0 for writes.
REQ-023 SHALL hold valid_o, fmo_o and rdata_o at 0 for all ports not responding in a given cycle.
REQ-024 SHALL return the updated data when a read of word W is granted the cycle after a write to W (write-then-read ordering, no stale data).
REQ-025 SHALL accept back-to-back grants to the same port, giving full throughput of one access per cycle in total.
REQ-026 SHALL sustain a pipeline overlapping the grant of one port with the response of another in the same cycle, with no interference between them.

Reset
REQ-027 SHALL, while rst_ni = 0, force:
- tcdm_valid_o = 0, tcdm_fmo_o = 0, tcdm_rdata_o = 0;
- ptr = 0;
- tcdm_gnt_o = 0 regardless of req.
REQ-028 SHALL drop any response pending at reset assertion; no valid is issued for it after release.
REQ-029 SHALL NOT reset storage contents; reads of never-written words return undefined data, which the bench must not check.
REQ-030 SHALL permit a first grant in the first rising edge cycle after rst_ni deasserts.

Verification
REQ-031 SHALL cover single write then read:
- port 0 writes addr 0x00010, data 0xDEADBEEF, be 1111;
- port 0 then reads 0x00010;
- required: gnt same cycle as each req; valid one cycle later; rdata 0xDEADBEEF, fmo 0.
REQ-032 SHALL cover byte enables:
- write 0xFFFFFFFF to 0x20;
- then write 0x00000000 with be 0101;
- read 0x20 returns 0xFF00FF00.
REQ-033 SHALL cover round-robin fairness:
- all four ports hold req for 8 cycles from reset;
- required grant order 0,1,2,3,0,1,2,3; each port's valid follows its grant by one cycle.
REQ-034 SHALL cover out-of-range access with DEPTH = 1024:
- port 2 writes 0x01000 with data 0x12345678;
- required: grant, then valid with fmo = 1 and rdata = 0;
- a subsequent read of 0x00000 shows the stored word unchanged.
REQ-035 SHALL cover write-then-read forwarding:
- port 1 writes 0xA5A5A5A5 to 0x40;
- port 3 reads 0x40 in the very next granted cycle;
- required: port 3 rdata = 0xA5A5A5A5.
REQ-036 SHALL cover reset mid-operation:
- assert rst_ni = 0 in the cycle after a granted read;
- required: valid stays 0 asynchronously;
- after release, ptr = 0: with ports 1 and 0 both requesting, port 0 is granted first.
